keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
// - Source end of the 5-bit key-code interface consumed by the calculator's operand/operator registers.
// - Scans a 4x4 active-low matrix keypad one column at a time and debounces presses.
// - Per debounced press: emits one 5-bit key code with a one-cycle key_valid strobe, which drives the register enable.
// - Idle/no-key code is 5'b11111 (5'h1F), the same sentinel the registers ignore.
// PARAMETERS
// - SCAN_DIV      1000   clock cycles each column is driven before its rows are sampled (>=4)
// - DEBOUNCE_CNT  50000  consecutive stable samples required for press and for release (>=2)
// - NO_KEY        5'h1F  idle code on key_code
// PORTS
// - clock      in   1  system clock; all logic on posedge
// - reset      in   1  asynchronous, active-high; clears all state immediately
// - row_n      in   4  keypad rows, active-low, externally pulled up, asynchronous to clock
// - col_n      out  4  column drive, active-low, exactly one bit low at all times
// - key_code   out  5  decoded key while held, else NO_KEY
// - key_valid  out  1  one-cycle pulse on the cycle a debounced press is accepted
// - key_held   out  1  high from the key_valid cycle until release completes
// BEHAVIOUR
// - Reset values: col_n=4'b1110, key_code=5'h1F, key_valid=0, key_held=0, state=SCAN, all counters 0.
// - row_n passes through a 2-flop synchronizer; all decisions use the synchronized value rs_n.
// - Key index = row*4+col (row/col 0..3; col c is driven when col_n[c]=0).
// - KEY_MAP, layout "1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D":
// -   digits -> 5'd0..5'd9, A=10 (add), B=11 (sub), C=12 (mul), D=13 (equals), *=14 (clear), #=15 (negate).
// - FSM states:
// - SCAN: div counter counts 0..SCAN_DIV-1 with the current column driven.
// -   At SCAN_DIV-1, rs_n==4'hF: rotate col_n left (1110->1101->1011->0111->1110), clear counter.
// -   At SCAN_DIV-1, any rs_n bit low: latch lowest-index low row plus current column; go DEBOUNCE.
// - DEBOUNCE: column held; each cycle the latched row low and all lower rows high increments stable count.
// -   Any other rs_n pattern: clear count, rotate column, return to SCAN.
// -   Count reaches DEBOUNCE_CNT-1: next cycle key_valid=1, key_code=KEY_MAP[index], key_held=1; go HELD.
// - HELD: column held; key_code stays valid; key_valid=0 after its single cycle.
// -   Release count increments while rs_n==4'hF and clears on any low bit.
// -   Count reaches DEBOUNCE_CNT-1: key_code=NO_KEY, key_held=0, rotate column; go SCAN.
// - Press latency: at most 4*SCAN_DIV + DEBOUNCE_CNT + 3 cycles after the synchronized press.
// - Exactly one key_valid per physical press; auto-repeat and second key while held are never reported.
// - Simultaneous keys: same column -> lowest row wins; other columns are unseen until release.
// - Reset mid-DEBOUNCE or mid-HELD: no key_valid is issued; outputs return to reset values asynchronously.
// - Counters saturate-free: width $clog2(max(SCAN_DIV,DEBOUNCE_CNT)); they always clear at terminal count.
// - key_code is never X; it equals NO_KEY whenever key_held=0.
// STRUCTURE
// - Shared package calc_pkg holds:
// -   NO_KEY and the key code constants (KEY_ADD=10, KEY_SUB=11, KEY_MUL=12, KEY_EQ=13, KEY_CLR=14, KEY_NEG=15).
// -   KEY_MAP as a 16-entry function.
// -   Scanner state enum {SCAN, DEBOUNCE, HELD}.
// - One sub-module: sync2 (2-flop synchronizer, WIDTH parameter), instanced on row_n.
// - Counters and FSM live in this module; key_code, key_valid and key_held are registered outputs.
// TESTING (SCAN_DIV=4, DEBOUNCE_CNT=8; bench keypad model drives row_n from col_n)
// - Reset, no keys:
// -   Required: col_n cycles 1110,1101,1011,0111 every 4 clocks; key_code=5'h1F, key_valid never high.
// - Hold key "5" (row1,col1) 40 cycles, then release:
// -   Required: exactly one key_valid with key_code=5'd5; key_held high; key_code=5'h1F ~8 cycles after release.
// - Hold key "D" (row3,col3):
// -   Required: key_code=5'd13. Hold key "*" (row3,col0): required key_code=5'd14.
// - Bounce: key "7" toggled every 3 cycles for 30 cycles, then stable for 20:
// -   Required: no key_valid during the toggling, exactly one key_valid (code 5'd7) after the stable period.
// - Rows 0 and 2 both low on col2 ("3" and "9"):
// -   Required: code 5'd3 only. While held, also press "1": required no second key_valid.
// - Assert reset 3 cycles into DEBOUNCE and mid-HELD:
// -   Required: outputs at reset values on the same edge; no key_valid; scanning restarts from col_n=1110.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator definitions: key codes, keypad layout and scanner states.
// Imported by the keypad scanner and the operand/operator register files.
package calc_pkg;

  localparam logic [4:0] NO_KEY  = 5'h1F;
  localparam logic [4:0] KEY_ADD = 5'd10;
  localparam logic [4:0] KEY_SUB = 5'd11;
  localparam logic [4:0] KEY_MUL = 5'd12;
  localparam logic [4:0] KEY_EQ  = 5'd13;
  localparam logic [4:0] KEY_CLR = 5'd14;
  localparam logic [4:0] KEY_NEG = 5'd15;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } scan_state_e;

  // Index is row*4+col; layout "1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D".
  function automatic logic [4:0] key_map(input logic [3:0] idx);
    logic [4:0] code;
    code = NO_KEY;
    unique case (idx)
      4'd0:  code = 5'd1;
      4'd1:  code = 5'd2;
      4'd2:  code = 5'd3;
      4'd3:  code = KEY_ADD;
      4'd4:  code = 5'd4;
      4'd5:  code = 5'd5;
      4'd6:  code = 5'd6;
      4'd7:  code = KEY_SUB;
      4'd8:  code = 5'd7;
      4'd9:  code = 5'd8;
      4'd10: code = 5'd9;
      4'd11: code = KEY_MUL;
      4'd12: code = KEY_CLR;
      4'd13: code = 5'd0;
      4'd14: code = KEY_NEG;
      4'd15: code = KEY_EQ;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs.
// RST_VAL lets pulled-up lines come out of reset at their idle level.
module sync2 #(
  parameter int              WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with press/release debounce.
// Emits one 5-bit key code and a single-cycle key_valid per press.
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [4:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CMAX = (SCAN_DIV > DEBOUNCE_CNT) ?
                        SCAN_DIV : DEBOUNCE_CNT;
  localparam int CW   = $clog2(CMAX);

  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CNT - 1);

  logic [3:0]    rs_n;
  scan_state_e   state_q;
  logic [CW-1:0] div_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    col_q;
  logic [1:0]    row_q;
  logic          any_low;
  logic [1:0]    first_row;

  sync2 #(
    .WIDTH   (4),
    .RST_VAL (4'hF)
  ) u_row_sync (
    .clock (clock),
    .reset (reset),
    .d     (row_n),
    .q     (rs_n)
  );

  assign col_n   = ~(4'b0001 << col_q);
  assign any_low = ~&rs_n;

  // Lowest-index low row wins when several share a column.
  always_comb begin
    first_row = 2'd0;
    priority case (1'b1)
      !rs_n[0]: first_row = 2'd0;
      !rs_n[1]: first_row = 2'd1;
      !rs_n[2]: first_row = 2'd2;
      !rs_n[3]: first_row = 2'd3;
      default:  first_row = 2'd0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= SCAN;
      div_q     <= '0;
      cnt_q     <= '0;
      col_q     <= 2'd0;
      row_q     <= 2'd0;
      key_code  <= NO_KEY;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      unique case (state_q)
        SCAN: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (any_low) begin
              row_q   <= first_row;
              cnt_q   <= '0;
              state_q <= DEBOUNCE;
            end else begin
              col_q <= col_q + 2'd1;
            end
          end else begin
            div_q <= div_q + CW'(1);
          end
        end
        DEBOUNCE: begin
          if (any_low && first_row == row_q) begin
            if (cnt_q == DEB_LAST) begin
              cnt_q     <= '0;
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              key_code  <= key_map({row_q, col_q});
              state_q   <= HELD;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end else begin
            cnt_q   <= '0;
            col_q   <= col_q + 2'd1;
            state_q <= SCAN;
          end
        end
        HELD: begin
          if (!any_low) begin
            if (cnt_q == DEB_LAST) begin
              cnt_q    <= '0;
              div_q    <= '0;
              key_code <= NO_KEY;
              key_held <= 1'b0;
              col_q    <= col_q + 2'd1;
              state_q  <= SCAN;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end else begin
            cnt_q <= '0;
          end
        end
        default: begin
          state_q <= SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a matrix keypad model.
// Small scan/debounce counts keep every scenario short.
module tb_keypad_scanner;
  import calc_pkg::*;

  localparam int SD = 4;
  localparam int DC = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [4:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys;

  int nvec    = 0;
  int nerr    = 0;
  int nvalid  = 0;
  int inv_bad = 0;
  logic [4:0] last_code = NO_KEY;

  always #5 clock = ~clock;

  // Pressed key shorts its row to the driven (low) column.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  keypad_scanner #(
    .SCAN_DIV     (SD),
    .DEBOUNCE_CNT (DC)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always @(negedge clock) begin
    if (key_valid === 1'b1) begin
      nvalid++;
      last_code = key_code;
    end
    if (!key_held && key_code !== NO_KEY) inv_bad++;
    if ((^key_code) === 1'bx) inv_bad++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic wait_valid(input int lim, output int n);
    n = 0;
    while (key_valid !== 1'b1 && n < lim) begin
      tick(1);
      n++;
    end
  endtask

  task automatic wait_release(input int lim, output int n);
    n = 0;
    while (key_held !== 1'b0 && n < lim) begin
      tick(1);
      n++;
    end
  endtask

  task automatic press(input string tag, input int idx,
                       input logic [4:0] exp);
    int n;
    int v0;
    v0   = nvalid;
    keys = 16'(1) << idx;
    wait_valid(80, n);
    check({tag, "_seen"}, 32'(n < 80), 1);
    check({tag, "_code"}, 32'(key_code), 32'(exp));
    check({tag, "_held"}, 32'(key_held), 1);
    tick(30);
    check({tag, "_hold_code"}, 32'(key_code), 32'(exp));
    check({tag, "_one_valid"}, nvalid - v0, 1);
    keys = '0;
    wait_release(40, n);
    check({tag, "_rel_lat"}, n, 10);
    check({tag, "_rel_code"}, 32'(key_code), 32'(NO_KEY));
  endtask

  initial begin
    int n;
    int v0;

    keys  = '0;
    reset = 1'b1;
    #1;
    check("rst_col", 32'(col_n), 32'hE);
    check("rst_code", 32'(key_code), 32'h1F);
    check("rst_valid", 32'(key_valid), 0);
    check("rst_held", 32'(key_held), 0);
    tick(2);
    reset = 1'b0;

    // Column advances once every SD clocks.
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      check("scan_col", 32'(col_n),
            32'(~(4'b0001 << ((k / SD) % 4)) & 4'hF));
    end
    check("idle_code", 32'(key_code), 32'h1F);
    check("idle_novalid", nvalid, 0);

    press("k5", 5, 5'd5);
    press("kD", 15, 5'd13);
    press("kstar", 12, 5'd14);

    // Bounce on "7": 3-cycle on/off, never stable long enough.
    v0 = nvalid;
    for (int i = 0; i < 10; i++) begin
      keys = (i % 2 == 0) ? 16'h0100 : 16'h0000;
      tick(3);
    end
    check("bounce_novalid", nvalid - v0, 0);
    keys = 16'h0100;
    tick(60);
    check("bounce_one", nvalid - v0, 1);
    check("bounce_code", 32'(last_code), 32'd7);
    check("bounce_held", 32'(key_held), 1);
    keys = '0;
    wait_release(40, n);
    check("bounce_rel", 32'(key_held), 0);

    // "3" and "9" share column 2; then "1" while held.
    v0   = nvalid;
    keys = 16'h0404;
    wait_valid(80, n);
    check("dual_seen", 32'(n < 80), 1);
    check("dual_code", 32'(key_code), 32'd3);
    keys = 16'h0405;
    tick(30);
    check("dual_one", nvalid - v0, 1);
    check("dual_code2", 32'(key_code), 32'd3);
    keys = '0;
    wait_release(40, n);
    check("dual_rel", 32'(key_held), 0);

    // Reset three cycles into DEBOUNCE.
    v0   = nvalid;
    keys = 16'h0020;
    n    = 0;
    while (dut.state_q != DEBOUNCE && n < 60) begin
      tick(1);
      n++;
    end
    check("deb_reach", 32'(n < 60), 1);
    tick(3);
    #2 reset = 1'b1;
    #1;
    check("deb_rst_col", 32'(col_n), 32'hE);
    check("deb_rst_code", 32'(key_code), 32'h1F);
    check("deb_rst_held", 32'(key_held), 0);
    tick(2);
    keys  = '0;
    reset = 1'b0;
    tick(1);
    check("deb_restart_col", 32'(col_n), 32'hE);
    tick(10);
    check("deb_novalid", nvalid - v0, 0);

    // Reset while a key is held.
    v0   = nvalid;
    keys = 16'h8000;
    wait_valid(80, n);
    check("held_seen", 32'(n < 80), 1);
    tick(4);
    #2 reset = 1'b1;
    #1;
    check("held_rst_col", 32'(col_n), 32'hE);
    check("held_rst_code", 32'(key_code), 32'h1F);
    check("held_rst_held", 32'(key_held), 0);
    check("held_rst_valid", 32'(key_valid), 0);
    tick(2);
    keys  = '0;
    reset = 1'b0;
    tick(1);
    check("held_restart_col", 32'(col_n), 32'hE);
    tick(20);
    check("held_valid_cnt", nvalid - v0, 1);

    check("code_invariant", inv_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
